// File: rtl/apb_periph_pkg.sv
// Shared APB peripheral-subsystem types, widths and default slave map.
// Rules are half-open [start_addr, end_addr); unused entries are empty.
package apb_periph_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;
  localparam int PSTRB_W = APB_DW / 8;
  localparam int MAX_SLAVES = 8;

  localparam int TIMER_REGS_QTY = 1024;
  localparam int RTC_REGS_QTY = 16;

  typedef struct packed {
    logic [7:0]        idx;
    logic [APB_AW-1:0] start_addr;
    logic [APB_AW-1:0] end_addr;
  } rule_t;

  typedef rule_t [MAX_SLAVES-1:0] addr_map_t;

  function automatic addr_map_t default_map();
    addr_map_t m;
    m = '0;
    m[0].idx = 8'd0;
    m[0].start_addr = 32'h0000_0000;
    m[0].end_addr = 32'(TIMER_REGS_QTY * 4);
    m[1].idx = 8'd1;
    m[1].start_addr = 32'h0000_1000;
    m[1].end_addr = 32'h0000_1000 + 32'(RTC_REGS_QTY * 4);
    return m;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational APB address decoder over a rule table.
// Lowest rule index wins when ranges overlap.
module apb_addr_decoder
  import apb_periph_pkg::*;
#(
  parameter int        AW         = 32,
  parameter int        SLAVES_QTY = 2,
  parameter int        IDX_W      = 1,
  parameter addr_map_t ADDR_MAP   = default_map()
) (
  input  logic [AW-1:0]    addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = SLAVES_QTY - 1; i >= 0; i--) begin
      if (addr >= AW'(ADDR_MAP[i].start_addr) &&
          addr <  AW'(ADDR_MAP[i].end_addr)) begin
        hit = 1'b1;
        idx = ADDR_MAP[i].idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/apb_periph_xbar.sv
// APB 1-to-N slave demultiplexer with decode-miss and PREADY-timeout
// error responses and a saturating error counter.
module apb_periph_xbar
  import apb_periph_pkg::addr_map_t, apb_periph_pkg::default_map;
#(
  parameter int        APB_AW      = apb_periph_pkg::APB_AW,
  parameter int        APB_DW      = apb_periph_pkg::APB_DW,
  parameter int        SLAVES_QTY  = 2,
  parameter addr_map_t ADDR_MAP    = default_map(),
  parameter int        TIMEOUT_CYC = 16,
  parameter int        ERR_CNT_W   = 8,
  localparam int       PSTRB_W     = APB_DW / 8
) (
  input  logic                         pclk,
  input  logic                         prst_n,
  input  logic                         s_psel,
  input  logic                         s_penable,
  input  logic                         s_pwrite,
  input  logic [APB_AW-1:0]            s_paddr,
  input  logic [APB_DW-1:0]            s_pwdata,
  input  logic [PSTRB_W-1:0]           s_pstrb,
  output logic                         s_pready,
  output logic [APB_DW-1:0]            s_prdata,
  output logic                         s_pslverr,
  output logic [SLAVES_QTY-1:0]        m_psel,
  output logic                         m_penable,
  output logic                         m_pwrite,
  output logic [APB_AW-1:0]            m_paddr,
  output logic [APB_DW-1:0]            m_pwdata,
  output logic [PSTRB_W-1:0]           m_pstrb,
  input  logic [SLAVES_QTY-1:0]        m_pready,
  input  logic [SLAVES_QTY*APB_DW-1:0] m_prdata,
  input  logic [SLAVES_QTY-1:0]        m_pslverr,
  output logic                         miss_evt,
  output logic                         tmo_evt,
  output logic [ERR_CNT_W-1:0]         err_cnt
);

  localparam int IDX_W = (SLAVES_QTY > 1) ? $clog2(SLAVES_QTY) : 1;
  localparam int TMO_W =
    (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE, ACC_HIT, ACC_MISS, TMO_RSP
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;
  logic             setup;
  logic             sel_rdy;
  logic             tmo_hit;
  logic [APB_DW-1:0] sel_rdata;

  apb_addr_decoder #(
    .AW         (APB_AW),
    .SLAVES_QTY (SLAVES_QTY),
    .IDX_W      (IDX_W),
    .ADDR_MAP   (ADDR_MAP)
  ) u_dec (
    .addr (s_paddr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  function automatic logic [SLAVES_QTY-1:0] onehot(
    input logic [IDX_W-1:0] i
  );
    return SLAVES_QTY'(1) << i;
  endfunction

  assign setup     = s_psel & ~s_penable;
  assign sel_rdy   = m_pready[idx_q];
  assign sel_rdata = m_prdata[idx_q*APB_DW +: APB_DW];
  assign tmo_hit   = (TIMEOUT_CYC != 0) && (tmo_cnt == TMO_LAST);

  assign m_penable = s_penable & (|m_psel);
  assign m_pwrite  = s_pwrite;
  assign m_paddr   = s_paddr;
  assign m_pwdata  = s_pwdata;
  assign m_pstrb   = s_pstrb;

  always_comb begin
    m_psel    = '0;
    s_pready  = 1'b0;
    s_prdata  = '0;
    s_pslverr = 1'b0;
    miss_evt  = 1'b0;
    tmo_evt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (setup && dec_hit) m_psel = onehot(dec_idx);
      end
      ACC_HIT: begin
        if (s_psel) begin
          m_psel   = onehot(idx_q);
          s_pready = sel_rdy;
          if (sel_rdy) begin
            s_prdata  = sel_rdata;
            s_pslverr = m_pslverr[idx_q];
          end
        end
      end
      ACC_MISS: begin
        if (s_psel) begin
          s_pready  = 1'b1;
          s_pslverr = 1'b1;
          miss_evt  = 1'b1;
        end
      end
      TMO_RSP: begin
        if (s_psel) begin
          s_pready  = 1'b1;
          s_pslverr = 1'b1;
          tmo_evt   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state   <= IDLE;
      idx_q   <= '0;
      tmo_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if ((miss_evt | tmo_evt) && !(&err_cnt))
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      unique case (state)
        IDLE: begin
          if (setup) begin
            tmo_cnt <= '0;
            idx_q   <= dec_idx;
            state   <= dec_hit ? ACC_HIT : ACC_MISS;
          end
        end
        ACC_HIT: begin
          if (!s_psel || sel_rdy) begin
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (tmo_hit) state <= TMO_RSP;
          end
        end
        ACC_MISS, TMO_RSP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_periph_xbar.sv
// Scoreboard bench for apb_periph_xbar: map slave0 [0,0x1000),
// slave1 [0x1000,0x1040), 16-cycle PREADY timeout, 8-bit error counter.
module tb_apb_periph_xbar;

  logic        pclk = 1'b0;
  logic        prst_n;
  logic        s_psel, s_penable, s_pwrite;
  logic [31:0] s_paddr, s_pwdata;
  logic [3:0]  s_pstrb;
  logic        s_pready, s_pslverr;
  logic [31:0] s_prdata;
  logic [1:0]  m_psel;
  logic        m_penable, m_pwrite;
  logic [31:0] m_paddr, m_pwdata;
  logic [3:0]  m_pstrb;
  logic [1:0]  m_pready;
  logic [63:0] m_prdata;
  logic [1:0]  m_pslverr;
  logic        miss_evt, tmo_evt;
  logic [7:0]  err_cnt;

  always #5 pclk = ~pclk;

  apb_periph_xbar #(
    .SLAVES_QTY  (2),
    .TIMEOUT_CYC (16),
    .ERR_CNT_W   (8)
  ) dut (
    .pclk      (pclk),
    .prst_n    (prst_n),
    .s_psel    (s_psel),
    .s_penable (s_penable),
    .s_pwrite  (s_pwrite),
    .s_paddr   (s_paddr),
    .s_pwdata  (s_pwdata),
    .s_pstrb   (s_pstrb),
    .s_pready  (s_pready),
    .s_prdata  (s_prdata),
    .s_pslverr (s_pslverr),
    .m_psel    (m_psel),
    .m_penable (m_penable),
    .m_pwrite  (m_pwrite),
    .m_paddr   (m_paddr),
    .m_pwdata  (m_pwdata),
    .m_pstrb   (m_pstrb),
    .m_pready  (m_pready),
    .m_prdata  (m_prdata),
    .m_pslverr (m_pslverr),
    .miss_evt  (miss_evt),
    .tmo_evt   (tmo_evt),
    .err_cnt   (err_cnt)
  );

  typedef struct {
    logic [1:0]  sel;
    int          cyc;
    logic [31:0] rd;
    logic        err;
    logic        miss;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   errs  = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_slave(input logic [31:0] a);
    if (a < 32'h1000) return 0;
    if (a < 32'h1040) return 1;
    return -1;
  endfunction

  task automatic drive_slave(input int slv, input int waits,
                             input int c, input logic [31:0] rd,
                             input logic err);
    m_prdata  = {32'hDEAD_BEEF, 32'hDEAD_BEEF};
    m_pslverr = {2{~err}};
    m_pready  = '0;
    if (slv < 0) begin
      m_pready = 2'b11;
    end else begin
      m_pready[slv] = (waits >= 0) && (c > waits);
      m_prdata[slv*32 +: 32] = rd;
      m_pslverr[slv] = err;
    end
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input int waits,
                      input logic err);
    exp_t e;
    int   slv;
    bit   done;
    slv    = ref_slave(addr);
    e.miss = (slv < 0);
    e.tmo  = !e.miss && (waits < 0 || waits >= 16);
    e.sel  = e.miss ? 2'b00 : 2'(1 << slv);
    e.cyc  = e.miss ? 1 : (e.tmo ? 17 : waits + 1);
    e.rd   = (e.miss || e.tmo) ? 32'h0 : data;
    e.err  = (e.miss || e.tmo) ? 1'b1 : err;
    @(posedge pclk); #1;
    s_psel = 1'b1; s_penable = 1'b0; s_pwrite = wr;
    s_paddr = addr; s_pwdata = data; s_pstrb = 4'hF;
    m_pready = '0;
    sb.push_back(e);
    @(negedge pclk);
    chk("setup_psel", 64'(m_psel), 64'(e.sel));
    chk("setup_pen", 64'(m_penable), 64'(0));
    chk("pwdata", 64'(m_pwdata), 64'(data));
    chk("paddr", 64'(m_paddr), 64'(addr));
    chk("pwrite", 64'(m_pwrite), 64'(wr));
    chk("err_cnt", 64'(err_cnt), 64'(errs));
    @(posedge pclk); #1;
    s_penable = 1'b1;
    done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      drive_slave(slv, waits, c, data, err);
      @(negedge pclk);
      if (s_pready) begin
        exp_t x;
        if (sb.size() == 0) begin
          chk("sb_empty", 64'(1), 64'(0));
        end else begin
          x = sb.pop_front();
          chk("rsp_cycle", 64'(c), 64'(x.cyc));
          chk("prdata", 64'(s_prdata), 64'(x.rd));
          chk("pslverr", 64'(s_pslverr), 64'(x.err));
          chk("miss_evt", 64'(miss_evt), 64'(x.miss));
          chk("tmo_evt", 64'(tmo_evt), 64'(x.tmo));
          chk("rsp_psel", 64'(m_psel),
              64'((x.miss || x.tmo) ? 2'b00 : x.sel));
          if (x.miss || x.tmo) errs = (errs == 255) ? 255 : errs + 1;
        end
        done = 1'b1;
      end else begin
        chk("wait_rsp", 64'({s_pslverr, s_prdata}), 64'(0));
        chk("wait_psel", 64'(m_psel), 64'(e.sel));
        @(posedge pclk); #1;
      end
    end
    if (!done) begin
      chk("no_pready", 64'(0), 64'(1));
      sb.delete();
    end
  endtask

  task automatic idle();
    @(posedge pclk); #1;
    s_psel = 1'b0; s_penable = 1'b0; m_pready = '0;
    @(negedge pclk);
    chk("idle_psel", 64'(m_psel), 64'(0));
    chk("idle_pready", 64'(s_pready), 64'(0));
    chk("idle_errcnt", 64'(err_cnt), 64'(errs));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    prst_n = 1'b0;
    s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0;
    s_paddr = '0; s_pwdata = '0; s_pstrb = '0;
    m_pready = '0; m_prdata = '0; m_pslverr = '0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk("rst_psel", 64'(m_psel), 64'(0));
    chk("rst_pen", 64'(m_penable), 64'(0));
    chk("rst_pready", 64'(s_pready), 64'(0));
    chk("rst_rsp", 64'({s_pslverr, s_prdata}), 64'(0));
    chk("rst_evts", 64'({miss_evt, tmo_evt}), 64'(0));
    chk("rst_errcnt", 64'(err_cnt), 64'(0));
    @(posedge pclk); #1;
    prst_n = 1'b1;

    xfer(1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 2, 1'b0);
    idle();
    xfer(1'b0, 32'h0000_1004, 32'h1234_5678, 1, 1'b1);
    idle();
    xfer(1'b0, 32'h0000_2000, 32'hCAFE_F00D, 0, 1'b0);
    idle();
    xfer(1'b0, 32'h0000_0010, 32'h1111_2222, -1, 1'b0);
    idle();
    xfer(1'b1, 32'h0000_0000, 32'h0BAD_0001, 0, 1'b0);
    xfer(1'b0, 32'h0000_1000, 32'h55AA_55AA, 0, 1'b0);
    idle();
    xfer(1'b0, 32'h0000_0FFC, 32'h0F0F_0F0F, 15, 1'b0);
    xfer(1'b0, 32'h0000_103C, 32'h3C3C_3C3C, 16, 1'b0);
    xfer(1'b0, 32'h0000_1040, 32'h4040_4040, 0, 1'b0);
    idle();

    @(posedge pclk); #1;
    s_psel = 1'b1; s_penable = 1'b0; s_pwrite = 1'b0;
    s_paddr = 32'h20; m_pready = '0;
    @(posedge pclk); #1;
    s_penable = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    prst_n = 1'b0;
    #1;
    chk("arst_psel", 64'(m_psel), 64'(0));
    chk("arst_pen", 64'(m_penable), 64'(0));
    chk("arst_pready", 64'(s_pready), 64'(0));
    chk("arst_rsp", 64'({s_pslverr, s_prdata}), 64'(0));
    chk("arst_evts", 64'({miss_evt, tmo_evt}), 64'(0));
    chk("arst_errcnt", 64'(err_cnt), 64'(0));
    errs = 0;
    @(posedge pclk); #1;
    s_psel = 1'b0; s_penable = 1'b0;
    @(posedge pclk); #1;
    prst_n = 1'b1;
    xfer(1'b0, 32'h0000_0008, 32'h7777_0008, 0, 1'b0);
    idle();

    repeat (300) xfer(1'b0, 32'h0000_3000, 32'h0, 0, 1'b0);
    idle();
    chk("err_sat", 64'(err_cnt), 64'(8'hFF));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
